// File: rtl/sub_bytes_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sub_bytes_seq_pkg
// Description : Shared constants and FSM encoding for the S-box byte
//               substitution sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package sub_bytes_seq_pkg;

  // The S-box ROM is addressed by one byte and answers one cycle later.
  localparam int SBOX_ADDR_W       = 8;
  localparam int SBOX_READ_LATENCY = 1;

  // Default state word size (AES state: 16 bytes).
  localparam int DEFAULT_STATE_BYTES = 16;

  // Sequencer FSM encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Width of the byte-pair counter; never narrower than one bit.
  function automatic int pair_cnt_w(input int state_bytes);
    return (state_bytes / 2 > 1) ? $clog2(state_bytes / 2) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// Module      : sub_bytes_seq
// Description : Feeds a state word through a shared dual-port S-box ROM, two
//               bytes per cycle, and reassembles the substituted word.
//               Port A serves even byte indices, port B odd ones. The ROM
//               read is registered, so returning data is qualified by a
//               one-cycle-delayed pending flag and pair index.
// Revision    : 1.0 - initial release
// ============================================================================
module sub_bytes_seq
  import sub_bytes_seq_pkg::*;
#(
  parameter int STATE_BYTES = DEFAULT_STATE_BYTES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [8*STATE_BYTES-1:0]   in_state,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [8*STATE_BYTES-1:0]   out_state,
  output logic [SBOX_ADDR_W-1:0]     sb_a_addr,
  output logic [SBOX_ADDR_W-1:0]     sb_b_addr,
  input  logic [7:0]                 sb_a_data,
  input  logic [7:0]                 sb_b_data
);

  localparam int PAIRS = STATE_BYTES / 2;
  localparam int K_W   = pair_cnt_w(STATE_BYTES);
  localparam int BI_W  = (STATE_BYTES > 2) ? $clog2(STATE_BYTES) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(PAIRS - 1);

  state_t                        r_state;
  logic [K_W-1:0]                r_k;
  logic [K_W-1:0]                r_k_d;
  logic                          r_pending;
  logic [STATE_BYTES-1:0][7:0]   r_src;
  logic [STATE_BYTES-1:0][7:0]   r_result;

  logic                          w_accept;
  logic [BI_W-1:0]               w_idx_a;
  logic [BI_W-1:0]               w_idx_b;
  logic [BI_W-1:0]               w_cap_a;
  logic [BI_W-1:0]               w_cap_b;

  // Handshakes are masked while reset is asserted so nothing leaks out.
  assign in_ready  = (r_state == ST_IDLE) && !rst;
  assign out_valid = (r_state == ST_DONE) && !rst;
  assign out_state = r_result;
  assign w_accept  = in_valid && in_ready;

  // Byte indices of the pair being issued and of the pair being captured.
  assign w_idx_a = BI_W'({r_k, 1'b0});
  assign w_idx_b = w_idx_a | BI_W'(1);
  assign w_cap_a = BI_W'({r_k_d, 1'b0});
  assign w_cap_b = w_cap_a | BI_W'(1);

  // Sequencer FSM and pair counter; the counter stops at the last pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_k     <= '0;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (r_k == K_LAST) begin
            r_state <= ST_DRAIN;
          end else begin
            r_k <= r_k + K_W'(1);
          end
        end
        ST_DRAIN: r_state <= ST_DONE;
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Source word is captured only on an accepted handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src <= '0;
    end else if (w_accept) begin
      r_src <= in_state;
    end
  end

  // Delay the issue qualifier by the ROM read latency (one cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_k_d     <= '0;
    end else begin
      r_pending <= (r_state == ST_ISSUE);
      r_k_d     <= r_k;
    end
  end

  // Write returning ROM bytes back into their original positions.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
    end else if (r_pending) begin
      r_result[w_cap_a] <= sb_a_data;
      r_result[w_cap_b] <= sb_b_data;
    end
  end

  // ROM addresses are the source bytes themselves; parked at zero otherwise.
  always_comb begin
    sb_a_addr = '0;
    sb_b_addr = '0;
    if ((r_state == ST_ISSUE) && !rst) begin
      sb_a_addr = r_src[w_idx_a];
      sb_b_addr = r_src[w_idx_b];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub_bytes_seq
// Description : Self-checking bench for sub_bytes_seq with a behavioural
//               1-cycle dual-port S-box ROM (mem[x] = x ^ 8'h63).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_bytes_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  // 16-byte instance
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_state, out_state;
  logic [7:0]   sb_a_addr, sb_b_addr, sb_a_data, sb_b_data;
  // 2-byte instance
  logic         in_valid2, in_ready2, out_valid2, out_ready2;
  logic [15:0]  in_state2, out_state2;
  logic [7:0]   sb_a_addr2, sb_b_addr2, sb_a_data2, sb_b_data2;

  logic [7:0]   mem [256];
  int           n_checks = 0;
  int           n_fail   = 0;
  int unsigned  cyc      = 0;

  sub_bytes_seq #(.STATE_BYTES(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .sb_a_addr(sb_a_addr), .sb_b_addr(sb_b_addr),
    .sb_a_data(sb_a_data), .sb_b_data(sb_b_data)
  );

  sub_bytes_seq #(.STATE_BYTES(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_state(in_state2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_state(out_state2),
    .sb_a_addr(sb_a_addr2), .sb_b_addr(sb_b_addr2),
    .sb_a_data(sb_a_data2), .sb_b_data(sb_b_data2)
  );

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h63;
  end

  // Registered-read ROM model for both instances.
  always @(posedge clk) begin
    sb_a_data  <= mem[sb_a_addr];
    sb_b_data  <= mem[sb_b_addr];
    sb_a_data2 <= mem[sb_a_addr2];
    sb_b_data2 <= mem[sb_b_addr2];
    cyc        <= cyc + 1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: substitute every byte of the word through the ROM table.
  function automatic logic [127:0] ref_sub(input logic [127:0] w, input int nb);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < nb; i++) r[8*i +: 8] = mem[w[8*i +: 8]];
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One transaction on the 16-byte instance: accept, address trace, latency,
  // result, optional backpressure of 'hold' cycles, completion.
  task automatic run_word(input logic [127:0] word, input int hold, input bit keep_valid,
                          output int unsigned t_acc, output logic [127:0] got);
    int n;
    bit acc;
    logic [127:0] exp, held;
    exp      = ref_sub(word, 16);
    got      = '0;
    t_acc    = 0;
    in_state = word;
    in_valid = 1'b1;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 40) begin
      acc = in_ready;
      tick();
      n++;
    end
    if (!acc) begin
      check("accept_timeout", 128'(0), 128'(1));
      in_valid = 1'b0;
      return;
    end
    t_acc     = cyc;
    in_valid  = keep_valid;
    in_state  = rand128();      // post-accept input changes must be ignored
    out_ready = 1'b1;           // high before DONE has no effect
    n = 0;
    while (!out_valid && n < 40) begin
      if (n < 8) begin
        check("addr_a", 128'(sb_a_addr), 128'(word[16*n +: 8]));
        check("addr_b", 128'(sb_b_addr), 128'(word[16*n+8 +: 8]));
      end else begin
        check("addr_a_idle", 128'(sb_a_addr), 128'(0));
        check("addr_b_idle", 128'(sb_b_addr), 128'(0));
        if (hold > 0) out_ready = 1'b0;
      end
      check("in_ready_busy", 128'(in_ready), 128'(0));
      tick();
      n++;
    end
    check("latency", 128'(n), 128'(9));
    check("out_state", out_state, exp);
    check("addr_done", 128'({sb_a_addr, sb_b_addr}), 128'(0));
    got  = out_state;
    held = out_state;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;          // ignored while DONE
      tick();
      check("hold_valid", 128'(out_valid), 128'(1));
      check("hold_state", out_state, held);
      check("hold_in_ready", 128'(in_ready), 128'(0));
    end
    in_valid  = keep_valid;
    out_ready = 1'b1;
    tick();
    check("complete", 128'(out_valid), 128'(0));
  endtask

  // One transaction on the 2-byte instance.
  task automatic run_word2(input logic [15:0] word, output logic [15:0] got);
    int n;
    bit acc;
    in_state2  = word;
    in_valid2  = 1'b1;
    out_ready2 = 1'b1;
    got = '0;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      acc = in_ready2;
      tick();
      n++;
    end
    in_valid2 = 1'b0;
    if (!acc) begin
      check("accept2_timeout", 128'(0), 128'(1));
      return;
    end
    n = 0;
    while (!out_valid2 && n < 20) begin
      tick();
      n++;
    end
    check("latency2", 128'(n), 128'(2));
    check("out_state2", 128'(out_state2), ref_sub(128'(word), 2));
    got = out_state2;
    tick();
    check("complete2", 128'(out_valid2), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t1, t2;
    logic [127:0] got;
    logic [15:0]  got2;
    bit           seen;
    rst = 1'b1;
    in_valid = 1'b0; in_state = '0; out_ready = 1'b0;
    in_valid2 = 1'b0; in_state2 = '0; out_ready2 = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_state", out_state, 128'(0));
    check("rst_addr", 128'({sb_a_addr, sb_b_addr}), 128'(0));
    check("rst_out_state2", 128'(out_state2), 128'(0));
    rst = 1'b0;
    #1;
    check("idle_in_ready", 128'(in_ready), 128'(1));
    check("idle_addr", 128'({sb_a_addr, sb_b_addr}), 128'(0));

    // Basic word with address trace
    run_word(128'h0F0E0D0C0B0A09080706050403020100, 0, 1'b0, t1, got);
    check("basic_const", got, 128'h6C6D6E6F68696A6B6465666760616263);

    // Backpressure for 20 cycles
    run_word(rand128(), 20, 1'b0, t1, got);

    // Back-to-back with in_valid held high
    run_word({16{8'hFF}}, 0, 1'b1, t1, got);
    check("b2b_first", got, {16{8'h9C}});
    run_word({16{8'h00}}, 0, 1'b0, t2, got);
    check("b2b_second", got, {16{8'h63}});
    check("b2b_period", 128'(t2 - t1), 128'(11));

    // Reset in the 4th ISSUE cycle
    in_state = rand128();
    in_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      seen = in_ready;
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 128'(in_ready), 128'(0));
    tick();
    rst = 1'b0;
    seen = 1'b0;
    tick();
    check("midrst_ready_after", 128'(in_ready), 128'(1));
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check("midrst_no_valid", 128'(seen), 128'(0));
    run_word(rand128(), 0, 1'b0, t1, got);

    // Reset and handshake in the same cycle: nothing captured
    in_state = rand128();
    in_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    check("rst_accept_idle", 128'(in_ready), 128'(1));
    check("rst_accept_addr", 128'({sb_a_addr, sb_b_addr}), 128'(0));

    // Random words with random backpressure
    for (int w = 0; w < 6; w++) begin
      run_word(rand128(), int'($urandom_range(0, 4)), 1'b0, t1, got);
    end

    // Two-byte instance
    run_word2(16'hA55A, got2);
    check("two_byte_const", 128'(got2), 128'(16'hC639));
    for (int w = 0; w < 3; w++) begin
      run_word2(16'($urandom), got2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
